// File: rtl/dmem_bytelane.sv
// RV32 byte-lane data memory with valid/ready request/response and wait states.
// Define DMEM_MISALIGN_FAULT_EN to fault misaligned halfword/word accesses.
module dmem_bytelane #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_e;

  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic fault_q, fault_d;

  logic we_q;
  logic [2:0] f3_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic commit;
  logic [ADDR_W-1:0] idx;
  logic [1:0] lane;
  logic illegal, misalign, fault;
  logic [3:0] be;
  logic [31:0] wword, rword, ldata;
  logic [7:0] rbyte;
  logic [15:0] rhalf;

  assign idx  = addr_q[ADDR_W+1:2];
  assign lane = addr_q[1:0];

  always_comb begin
    illegal = 1'b0;
    case (f3_q)
      3'b000, 3'b001, 3'b010: illegal = 1'b0;
      3'b100, 3'b101:         illegal = we_q;
      default:                illegal = 1'b1;
    endcase
  end

`ifdef DMEM_MISALIGN_FAULT_EN
  always_comb begin
    misalign = 1'b0;
    if (f3_q[1:0] == 2'b01)
      misalign = lane[0];
    else if (f3_q[1:0] == 2'b10)
      misalign = (lane != 2'b00);
  end
`else
  assign misalign = 1'b0;
`endif

  assign fault = illegal | misalign;

  // Store data is replicated across lanes so the enables alone pick the target
  always_comb begin
    be    = 4'hF;
    wword = wdata_q;
    case (f3_q[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata_q[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wword = wdata_q;
      end
    endcase
  end

  assign rword = mem_q[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ldata = 32'd0;
    case (f3_q)
      3'b000:  ldata = {{24{rbyte[7]}}, rbyte};
      3'b001:  ldata = {{16{rhalf[15]}}, rhalf};
      3'b010:  ldata = rword;
      3'b100:  ldata = {24'd0, rbyte};
      3'b101:  ldata = {16'd0, rhalf};
      default: ldata = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    fault_d   = fault_q;
    commit    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = S_ACCESS;
          cnt_d   = WAIT_STATES[3:0];
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = S_RESP;
          fault_d = fault;
          rdata_d = (fault || we_q) ? 32'd0 : ldata;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req_valid) begin
      we_q    <= req_we;
      f3_q    <= req_funct3;
      addr_q  <= req_addr[ADDR_W+1:0];
      wdata_q <= req_wdata;
    end
  end

  // Reset wins over a commit on the same edge
  always_ff @(posedge clk) begin
    if (commit && we_q && !fault && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem_q[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

endmodule

// File: tb/tb_dmem_bytelane.sv
// Randomised bench for dmem_bytelane: two instances (0 and 3 wait states)
// checked against a byte-array reference memory.
module tb_dmem_bytelane;

  localparam int DW = 256;
  localparam int NB = DW * 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_fault [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mref [2][NB];

  dmem_bytelane #(.DEPTH_WORDS(DW), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
  );

  dmem_bytelane #(.DEPTH_WORDS(DW), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
  );

  function automatic int wait_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: byte-addressed memory, size from funct3, aligned down
  task automatic model(input int d, input bit we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output bit ft);
    int size, ba, base;
    bit ill;
    logic [31:0] v;
    ill  = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) || (f3[2] && we);
    size = 1 << f3[1:0];
    ba   = int'(a & 32'(NB - 1));
    ft   = ill;
`ifdef DMEM_MISALIGN_FAULT_EN
    if (!ill && (ba % size) != 0) ft = 1'b1;
`endif
    base = ba - (ba % size);
    rd   = 32'd0;
    if (!ft) begin
      if (we) begin
        for (int k = 0; k < size; k++)
          mref[d][base + k] = wd[8*k +: 8];
      end else begin
        v = 32'd0;
        for (int k = 0; k < size; k++)
          v = v | (32'(mref[d][base + k]) << (8 * k));
        if (!f3[2] && size < 4 && v[8*size - 1])
          v = v | (32'hFFFF_FFFF << (8 * size));
        rd = v;
      end
    end
  endtask

  task automatic txn(input int d, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold,
                     output logic [31:0] rd, output logic ft,
                     output int lat, output bit stable, output bit post);
    @(negedge clk);
    req_valid[d]  = 1'b1;
    req_we[d]     = we;
    req_funct3[d] = f3;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    rsp_ready[d]  = 1'b0;
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (rsp_valid[d] !== 1'b1 && lat < 40);
    rd = rsp_rdata[d];
    ft = rsp_fault[d];
    stable = 1'b1;
    repeat (hold) begin
      @(posedge clk);
      #1;
      if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== rd ||
          rsp_fault[d] !== ft || req_ready[d] !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready[d] = 1'b0;
    post = (rsp_valid[d] === 1'b0) && (req_ready[d] === 1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 ||
          rsp_rdata[d] !== 32'd0 || rsp_fault[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: rdy=%b vld=%b rdata=%h fault=%b want 1 0 0 0",
                 d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_fault[d]);
      end
    end
  endtask

  task automatic test_fill();
    logic [31:0] rd, erd, wd;
    logic ft;
    bit eft, st, po;
    int lat;
    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < DW; w++) begin
        wd = $urandom;
        model(d, 1'b1, 3'b010, 32'(w * 4), wd, erd, eft);
        txn(d, 1'b1, 3'b010, 32'(w * 4), wd, 0, rd, ft, lat, st, po);
        checks++;
        if (rd !== 32'd0 || ft !== 1'b0 || lat != 1 + wait_of(d) || !po) begin
          errors++;
          $display("FAIL fill dut%0d w%0d: rdata=%h fault=%b lat=%0d post=%b want 0 0 %0d 1",
                   d, w, rd, ft, lat, po, 1 + wait_of(d));
        end
      end
    end
  endtask

  task automatic test_directed();
    logic [31:0] rd, erd;
    logic ft;
    bit eft, st, po;
    int lat;
    model(0, 1'b1, 3'b010, 32'h10, 32'h11223344, erd, eft);
    txn(0, 1'b1, 3'b010, 32'h10, 32'h11223344, 0, rd, ft, lat, st, po);
    model(0, 1'b0, 3'b010, 32'h10, 32'd0, erd, eft);
    txn(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== 32'h11223344 || ft !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL lw_basic: rdata=%h fault=%b lat=%0d want 11223344 0 1", rd, ft, lat);
    end
    model(0, 1'b1, 3'b000, 32'h12, 32'h000000AB, erd, eft);
    txn(0, 1'b1, 3'b000, 32'h12, 32'h000000AB, 0, rd, ft, lat, st, po);
    model(0, 1'b0, 3'b000, 32'h12, 32'd0, erd, eft);
    txn(0, 1'b0, 3'b000, 32'h12, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== 32'hFFFFFFAB) begin
      errors++;
      $display("FAIL lb: rdata=%h want ffffffab", rd);
    end
    txn(0, 1'b0, 3'b100, 32'h12, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== 32'h000000AB) begin
      errors++;
      $display("FAIL lbu: rdata=%h want 000000ab", rd);
    end
    txn(0, 1'b0, 3'b010, 32'h10, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== 32'h11AB3344) begin
      errors++;
      $display("FAIL sb_merge: rdata=%h want 11ab3344", rd);
    end
    model(0, 1'b1, 3'b001, 32'h16, 32'h00008001, erd, eft);
    txn(0, 1'b1, 3'b001, 32'h16, 32'h00008001, 0, rd, ft, lat, st, po);
    txn(0, 1'b0, 3'b001, 32'h16, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh: rdata=%h want ffff8001", rd);
    end
    txn(0, 1'b0, 3'b101, 32'h16, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu: rdata=%h want 00008001", rd);
    end
    model(0, 1'b0, 3'b001, 32'h15, 32'd0, erd, eft);
    txn(0, 1'b0, 3'b001, 32'h15, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== erd || ft !== eft) begin
      errors++;
      $display("FAIL lh_misalign: rdata=%h fault=%b want %h %b", rd, ft, erd, eft);
    end
  endtask

  task automatic test_wait_hold();
    logic [31:0] rd, erd, wd;
    logic ft;
    bit eft, st, po;
    int lat;
    wd = $urandom;
    model(1, 1'b1, 3'b010, 32'h40, wd, erd, eft);
    txn(1, 1'b1, 3'b010, 32'h40, wd, 0, rd, ft, lat, st, po);
    txn(1, 1'b0, 3'b010, 32'h40, 32'd0, 4, rd, ft, lat, st, po);
    checks++;
    if (rd !== wd || lat != 4 || !st || !po) begin
      errors++;
      $display("FAIL wait_hold: rdata=%h lat=%0d stable=%b post=%b want %h 4 1 1",
               rd, lat, st, po, wd);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd, old;
    logic ft;
    bit eft, st, po;
    int lat;
    model(0, 1'b0, 3'b010, 32'h20, 32'd0, old, eft);
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b1;
    req_funct3[0] = 3'b010;
    req_addr[0]   = 32'h20;
    req_wdata[0]  = ~old;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) begin
      checks++;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
        errors++;
        $display("FAIL abort_commit: vld=%b rdy=%b want 0 1", rsp_valid[0], req_ready[0]);
      end
      @(posedge clk);
      #1;
    end
    txn(0, 1'b0, 3'b010, 32'h20, 32'd0, 0, rd, ft, lat, st, po);
    checks++;
    if (rd !== old || ft !== 1'b0) begin
      errors++;
      $display("FAIL abort_nowrite: rdata=%h fault=%b want %h 0", rd, ft, old);
    end
    @(negedge clk);
    req_valid[0]  = 1'b1;
    req_we[0]     = 1'b0;
    req_funct3[0] = 3'b010;
    req_addr[0]   = 32'h20;
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== old) begin
      errors++;
      $display("FAIL resp_before_drop: vld=%b rdata=%h want 1 %h", rsp_valid[0], rsp_rdata[0], old);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || req_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL resp_drop: vld=%b rdata=%h rdy=%b want 0 0 1",
               rsp_valid[0], rsp_rdata[0], req_ready[0]);
    end
  endtask

  task automatic test_fault();
    logic [2:0] f3s [5];
    bit wes [5];
    logic [31:0] rd, erd, a, wd;
    logic ft;
    bit eft, st, po;
    int lat;
    f3s = '{3'b011, 3'b110, 3'b111, 3'b100, 3'b101};
    wes = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      a  = 32'h30 + 32'(i * 4);
      wd = $urandom;
      model(0, wes[i], f3s[i], a, wd, erd, eft);
      txn(0, wes[i], f3s[i], a, wd, 0, rd, ft, lat, st, po);
      checks++;
      if (ft !== 1'b1 || rd !== 32'd0) begin
        errors++;
        $display("FAIL illegal f3=%b we=%b: fault=%b rdata=%h want 1 0", f3s[i], wes[i], ft, rd);
      end
      model(0, 1'b0, 3'b010, a, 32'd0, erd, eft);
      txn(0, 1'b0, 3'b010, a, 32'd0, 0, rd, ft, lat, st, po);
      checks++;
      if (rd !== erd) begin
        errors++;
        $display("FAIL illegal_nowrite f3=%b: rdata=%h want %h", f3s[i], rd, erd);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd;
    logic [2:0] f3;
    logic ft;
    bit eft, st, po, we;
    int lat, d, hold;
    for (int n = 0; n < 300; n++) begin
      d    = $urandom_range(0, 1);
      we   = 1'($urandom_range(0, 1));
      f3   = 3'($urandom_range(0, 7));
      a    = $urandom;
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      model(d, we, f3, a, wd, erd, eft);
      txn(d, we, f3, a, wd, hold, rd, ft, lat, st, po);
      checks++;
      if (rd !== erd || ft !== eft || lat != 1 + wait_of(d) || !st || !po) begin
        errors++;
        $display("FAIL random #%0d dut%0d we=%b f3=%b a=%h: rdata=%h fault=%b lat=%0d st=%b post=%b want %h %b %0d 1 1",
                 n, d, we, f3, a, rd, ft, lat, st, po, erd, eft, 1 + wait_of(d));
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_we[d]     = 1'b0;
      req_funct3[d] = 3'b000;
      req_addr[d]   = 32'd0;
      req_wdata[d]  = 32'd0;
      rsp_ready[d]  = 1'b0;
    end
    rst = 1'b1;
    test_reset();
    test_fill();
    test_directed();
    test_wait_hold();
    test_reset_abort();
    test_fault();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
